// File: rtl/scrambler_pkg.sv
// Shared constants and types for the 127-bit, 16-bit-per-step scrambler.
//   STATE_W  : LFSR state width (fixed by the polynomial)
//   WORD_W   : bits consumed per step
//   TAP_LIST : state bits that also take the feedback bit
//   TAP_MASK : TAP_LIST as a bit mask
//   fsm_state_e : frame controller states
package scrambler_pkg;

    localparam int unsigned STATE_W = 127;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_TAPS  = 5;

    localparam int unsigned TAP_LIST [N_TAPS] = '{31, 38, 67, 68, 97};

    // Bit 0 is not part of the mask; it always takes the feedback bit xor data.
    localparam logic [STATE_W-1:0] TAP_MASK =
          (STATE_W'(1) << TAP_LIST[0])
        | (STATE_W'(1) << TAP_LIST[1])
        | (STATE_W'(1) << TAP_LIST[2])
        | (STATE_W'(1) << TAP_LIST[3])
        | (STATE_W'(1) << TAP_LIST[4]);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/scrambler_frame_ctrl_if.sv
// Word-stream and signature handshakes of the frame controller.
//   in_valid/in_ready/in_data/in_last : word stream from the framer
//   sig_valid/sig_ready/sig_data/sig_len/sig_err : signature to the checker
//   master : framer + checker side; slave : frame controller side
interface scrambler_frame_ctrl_if #(
    parameter int unsigned CNT_W = 11
) ();

    logic                                in_valid;
    logic                                in_ready;
    logic [scrambler_pkg::WORD_W-1:0]    in_data;
    logic                                in_last;
    logic                                sig_valid;
    logic                                sig_ready;
    logic [scrambler_pkg::STATE_W-1:0]   sig_data;
    logic [CNT_W-1:0]                    sig_len;
    logic                                sig_err;

    modport master (
        output in_valid, in_data, in_last, sig_ready,
        input  in_ready, sig_valid, sig_data, sig_len, sig_err
    );

    modport slave (
        input  in_valid, in_data, in_last, sig_ready,
        output in_ready, sig_valid, sig_data, sig_len, sig_err
    );

endinterface

// File: rtl/scrambler_step16.sv
// Combinational 16-bit step of the 127-bit LFSR; word bit 0 is applied first.
//   state_i      : current state
//   word_i       : data word
//   next_state_c : state after all WORD_W bits
module scrambler_step16
    import scrambler_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic [STATE_W-1:0] next_state_c
);

    // Unrolled chain of single-bit steps.
    always_comb begin
        logic [STATE_W-1:0] s;
        logic [WORD_W-1:0]  w;
        logic               msb;
        s   = state_i;
        w   = word_i;
        msb = 1'b0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            msb = s[STATE_W-1];
            s   = {s[STATE_W-2:0], w[0] ^ msb} ^ (TAP_MASK & {STATE_W{msb}});
            w   = w >> 1;
        end
        next_state_c = s;
    end

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer: seeds the LFSR, steps it once per accepted word and
// presents the final state, word count and length-error flag as a signature.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : begin a frame with seed (IDLE only)
//   seed      : initial LFSR state
//   abort     : drop the current frame from any state
//   busy      : high in RUN and DONE
//   bus       : word stream in, signature out (slave side)
module scrambler_frame_ctrl
    import scrambler_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [STATE_W-1:0]  seed,
    input  logic                abort,
    output logic                busy,
    scrambler_frame_ctrl_if.slave bus
);

    fsm_state_e         state_q, state_d;
    logic [STATE_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               sig_valid_q, sig_valid_d;
    logic               busy_q, busy_d;

    logic [STATE_W-1:0] step_c;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    scrambler_step16 u_step (
        .state_i      (lfsr_q),
        .word_i       (bus.in_data),
        .next_state_c (step_c)
    );

    // Next-state, datapath updates and registered handshake decodes.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        accept      = bus.in_valid & in_ready_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lfsr_d  = seed;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        lfsr_d = step_c;
                        cnt_d  = cnt_inc;
                        // in_last takes precedence over hitting the limit.
                        if (bus.in_last) begin
                            err_d   = 1'b0;
                            state_d = DONE;
                        end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.sig_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Handshake outputs are flops decoded from the next state.
        in_ready_d  = (state_d == RUN);
        sig_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            sig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            sig_valid_q <= sig_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sig_valid = sig_valid_q;
    assign bus.sig_data  = lfsr_q;
    assign bus.sig_len   = cnt_q;
    assign bus.sig_err   = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Scoreboard bench for scrambler_frame_ctrl with MAX_WORDS=4.
module tb_scrambler_frame_ctrl;
    import scrambler_pkg::*;

    localparam int unsigned MAXW = 4;
    localparam int unsigned CW   = 11;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [126:0] seed  = '0;
    logic         busy;

    always #5 clk = ~clk;

    scrambler_frame_ctrl_if #(.CNT_W(CW)) bus ();

    scrambler_frame_ctrl #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .seed  (seed),
        .abort (abort),
        .busy  (busy),
        .bus   (bus)
    );

    typedef struct {
        logic [126:0] d;
        logic [10:0]  len;
        logic         err;
    } exp_t;

    exp_t         expq[$];
    logic [15:0]  wq[$];
    logic         lq[$];
    int           checks   = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [126:0] act, input logic [126:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [126:0] rand127();
        return 127'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Reference: one bit at a time, feedback toggles bit 0 and each tap.
    function automatic logic [126:0] ref_step(input logic [126:0] s_in, input logic [15:0] w);
        int taps [5];
        logic [126:0] s;
        logic fb;
        logic d;
        taps = '{31, 38, 67, 68, 97};
        s = s_in;
        for (int b = 0; b < 16; b++) begin
            fb = s[126];
            d  = 1'((w >> b) & 16'h1);
            s  = s << 1;
            s  = s | 127'(fb ^ d);
            if (fb) begin
                for (int t = 0; t < 5; t++) s = s ^ (127'(1) << taps[t]);
            end
        end
        return s;
    endfunction

    // Reference frame result for the words/lasts held in wq/lq.
    function automatic exp_t ref_frame(input logic [126:0] sd);
        exp_t e;
        int   cnt;
        logic [126:0] s;
        s = sd; cnt = 0; e.err = 1'b0;
        for (int i = 0; i < wq.size(); i++) begin
            s = ref_step(s, wq[i]);
            cnt++;
            if (lq[i]) break;
            if (cnt == int'(MAXW)) begin
                e.err = 1'b1;
                break;
            end
        end
        e.d = s;
        e.len = 11'(cnt);
        return e;
    endfunction

    // Drive one complete frame and its signature handshake.
    task automatic send_frame(input logic [126:0] sd, input exp_t e, input int hold, input int max_gap);
        int g;
        expq.push_back(e);
        start = 1'b1; seed = sd;
        tick();
        start = 1'b0; seed = rand127();
        chk("busy_in_run", 127'(busy), 127'(1));
        for (int i = 0; i < int'(e.len); i++) begin
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
            repeat ($urandom_range(0, max_gap)) tick();
            bus.in_valid = 1'b1; bus.in_data = wq[i]; bus.in_last = lq[i];
            start = ($urandom_range(0, 2) == 0);
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 8) begin tick(); g++; end
            chk("in_ready_run", 127'(bus.in_ready), 127'(1));
            tick();
            start = 1'b0;
        end
        bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_data = 16'($urandom());
        chk("sig_valid_latency", 127'(bus.sig_valid), 127'(1));
        chk("in_ready_done", 127'(bus.in_ready), 127'(0));
        start = 1'b1;
        repeat (hold) tick();
        start = 1'b0;
        bus.sig_ready = 1'b1;
        tick();
        bus.sig_ready = 1'b0; bus.in_valid = 1'b0;
        chk("sig_valid_after_hs", 127'(bus.sig_valid), 127'(0));
        chk("busy_after_hs", 127'(busy), 127'(0));
    endtask

    // Monitor: pops expected signatures on handshakes, checks hold stability.
    logic         prev_valid = 1'b0;
    logic         prev_moved = 1'b1;
    logic [126:0] prev_d;
    logic [10:0]  prev_len;
    logic         prev_err;
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.sig_valid && prev_valid && !prev_moved) begin
            chk("hold_data", bus.sig_data, prev_d);
            chk("hold_len", 127'(bus.sig_len), 127'(prev_len));
            chk("hold_err", 127'(bus.sig_err), 127'(prev_err));
        end
        if (rst && bus.sig_valid && bus.sig_ready && !abort) begin
            if (expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_signature: got data %h with no frame pending", bus.sig_data);
            end else begin
                e = expq.pop_front();
                chk("sig_data", bus.sig_data, e.d);
                chk("sig_len", 127'(bus.sig_len), 127'(e.len));
                chk("sig_err", 127'(bus.sig_err), 127'(e.err));
            end
        end
        prev_valid = rst & bus.sig_valid;
        prev_moved = bus.sig_ready | abort;
        prev_d     = bus.sig_data;
        prev_len   = bus.sig_len;
        prev_err   = bus.sig_err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [126:0] sd;
        logic [126:0] m;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.sig_ready = 1'b0;

        repeat (2) tick();
        chk("rst_in_ready", 127'(bus.in_ready), 127'(0));
        chk("rst_sig_valid", 127'(bus.sig_valid), 127'(0));
        chk("rst_busy", 127'(busy), 127'(0));
        chk("rst_sig_data", bus.sig_data, 127'(0));
        chk("rst_sig_len", 127'(bus.sig_len), 127'(0));
        chk("rst_sig_err", 127'(bus.sig_err), 127'(0));
        @(negedge clk); rst = 1'b1;
        tick();

        bus.in_valid = 1'b1;
        tick();
        chk("idle_ignores_valid", 127'(bus.in_ready), 127'(0));
        chk("idle_not_busy", 127'(busy), 127'(0));
        bus.in_valid = 1'b0;

        // Directed single-word frames with known signatures.
        wq = '{16'h0001}; lq = '{1'b1};
        e.d = 127'h8000; e.len = 11'd1; e.err = 1'b0;
        send_frame(127'(0), e, 0, 0);

        wq = '{16'h0000}; lq = '{1'b1};
        e.d = 127'h10000; e.len = 11'd1; e.err = 1'b0;
        send_frame(127'(1), e, 1, 0);

        m = '0;
        m = m | (127'(1) << 15) | (127'(1) << 46) | (127'(1) << 53)
              | (127'(1) << 82) | (127'(1) << 83) | (127'(1) << 112);
        wq = '{16'h0000}; lq = '{1'b1};
        e.d = m; e.len = 11'd1; e.err = 1'b0;
        send_frame(127'(1) << 126, e, 0, 0);

        // Limit reached without in_last.
        sd = rand127();
        wq = {}; lq = {};
        for (int i = 0; i < 4; i++) begin wq.push_back(16'($urandom())); lq.push_back(1'b0); end
        e = ref_frame(sd); e.len = 11'd4; e.err = 1'b1;
        send_frame(sd, e, 2, 1);

        // in_last coinciding with the limit.
        sd = rand127();
        wq = {}; lq = {};
        for (int i = 0; i < 4; i++) begin wq.push_back(16'($urandom())); lq.push_back(i == 3); end
        e = ref_frame(sd); e.len = 11'd4; e.err = 1'b0;
        send_frame(sd, e, 0, 0);

        // Seed 0, three words with gaps, signature held for 5 cycles.
        wq = '{16'hA5C3, 16'h0F0F, 16'h1234}; lq = '{1'b0, 1'b0, 1'b1};
        e = ref_frame(127'(0));
        send_frame(127'(0), e, 5, 3);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int n;
            logic no_last;
            n = int'($urandom_range(1, 4));
            no_last = (n == 4) && ($urandom_range(0, 1) == 1);
            wq = {}; lq = {};
            for (int i = 0; i < n; i++) begin
                wq.push_back(16'($urandom()));
                lq.push_back(!no_last && (i == n - 1));
            end
            sd = rand127();
            e = ref_frame(sd);
            send_frame(sd, e, int'($urandom_range(0, 3)), 2);
        end

        // abort together with start and a last word in RUN.
        start = 1'b1; seed = rand127(); tick(); start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'($urandom()); bus.in_last = 1'b0; tick();
        abort = 1'b1; start = 1'b1; bus.in_last = 1'b1; tick();
        abort = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("abort_busy", 127'(busy), 127'(0));
        chk("abort_in_ready", 127'(bus.in_ready), 127'(0));
        chk("abort_sig_valid", 127'(bus.sig_valid), 127'(0));
        repeat (3) tick();
        chk("abort_no_sig", 127'(bus.sig_valid), 127'(0));

        // abort beats the signature handshake in DONE.
        start = 1'b1; seed = rand127(); tick(); start = 1'b0;
        bus.in_valid = 1'b1; bus.in_last = 1'b1; tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("done_before_abort", 127'(bus.sig_valid), 127'(1));
        abort = 1'b1; bus.sig_ready = 1'b1; tick();
        abort = 1'b0; bus.sig_ready = 1'b0;
        chk("abort_done_valid", 127'(bus.sig_valid), 127'(0));
        chk("abort_done_busy", 127'(busy), 127'(0));

        // Asynchronous reset mid-RUN.
        start = 1'b1; seed = rand127() | 127'(1); tick(); start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'($urandom()); bus.in_last = 1'b0; tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_sig_data", bus.sig_data, 127'(0));
        chk("arst_sig_len", 127'(bus.sig_len), 127'(0));
        chk("arst_sig_err", 127'(bus.sig_err), 127'(0));
        chk("arst_in_ready", 127'(bus.in_ready), 127'(0));
        chk("arst_sig_valid", 127'(bus.sig_valid), 127'(0));
        chk("arst_busy", 127'(busy), 127'(0));
        bus.in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        tick();

        // Recovery frame after reset.
        sd = rand127();
        wq = '{16'($urandom()), 16'($urandom())}; lq = '{1'b0, 1'b1};
        e = ref_frame(sd);
        send_frame(sd, e, 1, 1);

        repeat (3) tick();
        chk("scoreboard_empty", 127'(expq.size()), 127'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scrambler_frame_ctrl.md
Name: scrambler_frame_ctrl

Overview:
Frame-level sequencer for the 127-bit, 16-bit-per-step scrambler/signature datapath.
- Loads a seed, accepts 16-bit words over a valid/ready handshake and advances the 127-bit state once per accepted word.
- At end of frame, presents the final state as a signature, with word count and length-error flag, over a second valid/ready handshake.
- Sits between the framer's word stream and the signature checker.

Parameters:
STATE_W, 127, LFSR state width; fixed by the polynomial, not to be overridden.
WORD_W, 16, bits consumed per step.
MAX_WORDS, 1024, maximum words per frame before a length error.
CNT_W, 11, word counter width; must be at least clog2(MAX_WORDS+1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a frame using seed. Honoured only in IDLE.
seed  input  STATE_W  initial state; sampled only on an honoured start.
abort  input  1  synchronous; discards the current frame from any state.
in_valid  input  1  word valid.
in_ready  output  1  word accepted when in_valid and in_ready are both high.
in_data  input  WORD_W  word; bit 0 is applied to the LFSR first.
in_last  input  1  marks the final word of the frame.
sig_valid  output  1  signature available.
sig_ready  input  1  signature consumed when sig_valid and sig_ready are both high.
sig_data  output  STATE_W  final LFSR state.
sig_len  output  CNT_W  number of words accepted in the frame.
sig_err  output  1  frame hit MAX_WORDS without in_last.
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; state register, counter, sig_data, sig_len and sig_err are 0; in_ready, sig_valid and busy are 0.
- Step function, per bit d, with msb = s[126]:
  - s'[0] = msb ^ d
  - s'[k] = s[k-1] ^ msb for k in {31, 38, 67, 68, 97}
  - otherwise s'[k] = s[k-1]
  - One word applies bits 0..15 in order, combinationally, within a single cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, sig_valid=0.
  - start: state <= seed, cnt <= 0, sig_err <= 0; next state RUN.
  - in_valid is ignored in IDLE.
- RUN:
  - in_ready=1.
  - On each accept: state <= step(state, in_data); cnt <= cnt+1.
  - Accept with in_last=1: next state DONE, sig_err=0.
  - Accept with in_last=0 where cnt+1 == MAX_WORDS: next state DONE, sig_err=1.
  - When in_last and the limit coincide, in_last wins (sig_err=0).
  - No accept: state and cnt hold.
- DONE:
  - in_ready=0, sig_valid=1.
  - sig_data = state register; sig_len = cnt.
  - Outputs are held stable while sig_ready=0.
  - Handshake: next state IDLE.
  - Latency: sig_valid rises the cycle after the last word is accepted.
- abort: next state IDLE from any state; sig_valid drops next cycle; no signature is emitted.
  - abort has priority over start, word accept and signature handshake in the same cycle.
- start in RUN or DONE is ignored; seed is not sampled.
- Minimum frame is 1 word. Zero-length frames are unsupported.
- Back-to-back frames: DONE handshake, then IDLE for at least 1 cycle, then start.
- in_ready and sig_valid are registered-state decodes only, with no combinational path from in_valid or sig_ready.

Decomposition:
- Package scrambler_pkg holds:
  - STATE_W and WORD_W constants
  - tap list constant {31, 38, 67, 68, 97}
  - FSM state enum {IDLE, RUN, DONE}
- Sub-module scrambler_step16: purely combinational, (state, word) -> next state, per the step function above.
- The controller owns the state register, counter, FSM and handshakes.

Test Plan:
- seed=0; one word in_data=16'h0001 with in_last=1 -> sig_data=127'h8000, sig_len=1, sig_err=0; sig_valid high 1 cycle after the accept.
- seed=127'h1; word 16'h0000 with in_last=1 -> sig_data=127'h10000.
- seed=1<<126; word 16'h0000 with in_last=1 -> sig_data has exactly bits {15, 46, 53, 82, 83, 112} set.
- MAX_WORDS=4; 4 words with in_last=0 -> DONE after the 4th accept, sig_len=4, sig_err=1; a 5th in_valid sees in_ready=0.
- Seed 0; 3-word frame with gaps in in_valid; sig_ready held low 5 cycles -> sig_data, sig_len and sig_valid are stable throughout; handshake returns to IDLE; start one cycle later begins a new frame.
- abort asserted mid-RUN together with start -> IDLE, no sig_valid; rst pulsed low mid-RUN -> all outputs 0 immediately, independent of clk.
